wb_dma_copy: RTL and testbench
==============================

Name: wb_dma_copy

Overview:
- Wishbone classic-cycle master (initiator) that copies a block of 32-bit words from a source address to a destination address on the system bus.
- Sits beside the CPU as a second bus master and targets the on-chip Wishbone RAM and peripherals.
- Software-side control is a start/busy/done/err strobe interface, driven by a register wrapper or test logic.

Parameters:
- LEN_W, 16, width of the word-count input; maximum transfer is 2^LEN_W - 1 words.
- TIMEOUT_CYCLES, 64, ack watchdog limit in clocks; used only when WB_DMA_TIMEOUT_EN is defined.

Ports:
- wb_clk_i  in  1  system clock; all logic is rising-edge.
- wb_rst_i  in  1  reset, asynchronous and active-high.
- start_i  in  1  one-cycle start pulse; sampled only in IDLE.
- src_adr_i  in  32  source byte address; bits [1:0] are ignored (treated as 0).
- dst_adr_i  in  32  destination byte address; bits [1:0] are ignored.
- len_i  in  LEN_W  number of words to copy.
- busy_o  out  1  high from the cycle after an accepted start until DONE.
- done_o  out  1  one-cycle completion pulse, issued for normal end and for abort.
- err_o  out  1  sticky abort flag; cleared by the next accepted start.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  write enable.
- wb_sel_o  out  4  byte selects; constant 4'hF.
- wb_adr_o  out  32  bus address; bits [1:0] are always 0.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  slave acknowledge.
- wb_err_i  in  1  slave error.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, all outputs 0, internal counters and data holding register 0.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - On start_i with len_i!=0: latch src, dst and len; clear err_o; go to RD.
  - On start_i with len_i==0: clear err_o; go directly to DONE; no bus cycle is issued.
- RD:
  - Outputs: cyc=stb=1, we=0, adr=current src.
  - On ack: latch wb_dat_i into the holding register, src+=4, go to WR.
- WR:
  - Outputs: cyc=stb=1, we=1, adr=current dst, dat=holding register.
  - On ack: dst+=4, remaining-1. If remaining reaches 0, go to DONE; otherwise go to RD.
- Bus signal timing:
  - adr, we and dat are held stable until ack is sampled.
  - cyc and stb stay high continuously across RD->WR->RD transitions. Only adr, we and dat change, on the clock edge that samples ack.
  - cyc and stb drop in the cycle after the final ack.
- Throughput: with a slave that registers ack one cycle after stb (and drops it the following cycle), each access takes 2 clocks, so each word takes 4 clocks.
  - Example: len=N completes with done_o N*4+1 cycles after start.
- DONE: done_o=1 for exactly one cycle, busy_o=0, cyc=stb=0, then IDLE.
- wb_err_i:
  - Sampled in RD or WR.
  - On err: abort immediately, set err_o=1, go to DONE. No further bus access is issued.
  - If ack and err are high together, err wins.
- Addresses increment modulo 2^32; wrap from 0xFFFFFFFC to 0x00000000 is allowed and silent.
- start_i while busy_o=1 is ignored, and the latched parameters are unchanged.
- busy_o is high in RD and WR only.

Optional Feature:
- Macro: WB_DMA_TIMEOUT_EN.
- Defined:
  - A watchdog counter resets on every state entry and counts clocks spent in RD or WR without ack/err.
  - Reaching TIMEOUT_CYCLES aborts exactly like wb_err_i: err_o=1, then DONE, and cyc/stb drop.
- Undefined: no counter; the master waits indefinitely for ack.

Test Plan:
- Normal copy: RAM model with words 0x100..0x10C = 11111111, 22222222, 33333333, 44444444; start with src=0x100, dst=0x200, len=4.
  - Required: RAM 0x200..0x20C holds the same values.
  - Required: done_o pulses 17 cycles after start.
  - Required: err_o=0 and wb_sel_o=F throughout.
- Zero length: len=0 -> done_o pulses the cycle after start; wb_cyc_o never rises; busy_o stays 0.
- Error abort: slave raises wb_err_i on the WR of word 2 of a len=4 transfer.
  - Required: err_o=1 and a single done_o pulse.
  - Required: dst words 2-4 are untouched.
  - Required: the next start with len=1 clears err_o and completes normally.
- Start while busy: second start_i with src=0x300 two cycles into a len=3 transfer -> ignored; the original 3 words are copied from the original src.
- Reset mid-transfer: assert wb_rst_i during WR of word 1 (asynchronous, between edges).
  - Required: cyc, stb, busy and done go to 0 immediately.
  - Required: after release, a fresh start completes correctly.
- Timeout (WB_DMA_TIMEOUT_EN defined, TIMEOUT_CYCLES=8): slave never acks -> cyc drops and err_o=1 with done_o 9-10 cycles after RD entry.

Source files
------------

// File: rtl/wb_dma_copy.sv
// wb_dma_copy: Wishbone classic-cycle master that copies a block of 32-bit words.
// Define WB_DMA_TIMEOUT_EN to add an ack watchdog of TIMEOUT_CYCLES clocks.
module wb_dma_copy #(
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start_i,
    input  logic [31:0]      src_adr_i,
    input  logic [31:0]      dst_adr_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [3:0]       wb_sel_o,
    output logic [31:0]      wb_adr_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [31:0] ADR_MASK = 32'hFFFF_FFFC;

    state_t           state, state_nx;
    logic [31:0]      src, dst, data;
    logic [LEN_W-1:0] rem;
    logic             err_r;
    logic             abort;

    // Handshakes: start_i is accepted only in IDLE. A bus access completes on the
    // edge that samples ack (or err) while stb is high; adr/we/dat hold until then.

`ifdef WB_DMA_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    assign abort = wb_err_i || (!wb_ack_i && wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wd_cnt <= '0;
        end else if (state_nx != state) begin
            wd_cnt <= '0;
        end else if ((state == RD || state == WR) && !wb_ack_i && !wb_err_i) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end
`else
    assign abort = wb_err_i;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start_i) state_nx = (len_i == '0) ? DONE : RD;
            RD: begin
                if (abort)         state_nx = DONE;
                else if (wb_ack_i) state_nx = WR;
            end
            WR: begin
                if (abort)         state_nx = DONE;
                else if (wb_ack_i) state_nx = (rem == LEN_W'(1)) ? DONE : RD;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            src   <= '0;
            dst   <= '0;
            data  <= '0;
            rem   <= '0;
            err_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        err_r <= 1'b0;
                        if (len_i != '0) begin
                            src <= src_adr_i & ADR_MASK;
                            dst <= dst_adr_i & ADR_MASK;
                            rem <= len_i;
                        end
                    end
                end
                RD: begin
                    if (abort) begin
                        err_r <= 1'b1;
                    end else if (wb_ack_i) begin
                        data <= wb_dat_i;
                        src  <= src + 32'd4;
                    end
                end
                WR: begin
                    if (abort) begin
                        err_r <= 1'b1;
                    end else if (wb_ack_i) begin
                        dst <= dst + 32'd4;
                        rem <= rem - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // cyc/stb are a pure function of state, so they stay high across RD<->WR.
    always_comb begin
        busy_o   = (state == RD) || (state == WR);
        done_o   = (state == DONE);
        wb_cyc_o = busy_o;
        wb_stb_o = busy_o;
        wb_we_o  = (state == WR);
        wb_adr_o = (state == RD) ? src : ((state == WR) ? dst : 32'd0);
    end

    assign err_o     = err_r;
    assign wb_sel_o  = 4'hF;
    assign wb_dat_o  = data;
    assign state_dbg = state;

endmodule

// File: tb/tb_wb_dma_copy.sv
// Self-checking bench for wb_dma_copy: Wishbone RAM slave model plus reference copy model.
// Build with WB_DMA_TIMEOUT_EN defined to also exercise the ack watchdog.
module tb_wb_dma_copy;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start;
    logic [31:0] src_adr, dst_adr;
    logic [15:0] len;
    logic        busy_o, done_o, err_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic        wb_ack_i, wb_err_i;
    logic [1:0]  state_dbg;

    logic [31:0] mem [0:1023];
    logic        bd_we;
    logic [9:0]  bd_idx;
    logic [31:0] bd_dat;
    logic [31:0] err_adr;
    logic        mute;

    logic [31:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int done_cnt = 0, cyc_cnt = 0, busy_cnt = 0, sel_bad = 0, err_hi = 0;

    wb_dma_copy #(.LEN_W(16), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start),
        .src_adr_i(src_adr), .dst_adr_i(dst_adr), .len_i(len),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // RAM slave: registered ack one cycle after stb, dropped the following cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_ack_i <= 1'b0;
            wb_err_i <= 1'b0;
            wb_dat_i <= 32'd0;
        end else begin
            wb_ack_i <= 1'b0;
            wb_err_i <= 1'b0;
            if (bd_we) mem[bd_idx] <= bd_dat;
            if (wb_cyc_o && wb_stb_o && !wb_ack_i && !wb_err_i && !mute) begin
                if (wb_we_o && wb_adr_o == err_adr) begin
                    wb_err_i <= 1'b1;
                end else begin
                    wb_ack_i <= 1'b1;
                    if (wb_we_o) mem[wb_adr_o[11:2]] <= wb_dat_o;
                    else         wb_dat_i <= mem[wb_adr_o[11:2]];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (done_o)            done_cnt++;
            if (wb_cyc_o)          cyc_cnt++;
            if (busy_o)            busy_cnt++;
            if (err_o)             err_hi++;
            if (wb_sel_o !== 4'hF) sel_bad++;
        end
    end

    function automatic logic [9:0] widx(input logic [31:0] a, input int i);
        logic [31:0] w;
        w = a + 32'(i * 4);
        return w[11:2];
    endfunction

    // driver tasks
    task automatic poke(input logic [9:0] idx, input logic [31:0] v);
        bd_idx = idx;
        bd_dat = v;
        bd_we  = 1'b1;
        @(posedge clk); #1;
        bd_we  = 1'b0;
    endtask

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] n, output int lat);
        lat = -1;
        src_adr = s; dst_adr = d; len = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 2000; k++) begin
            if (done_o) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o, err_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {wb_cyc_o, wb_stb_o, wb_we_o, busy_o, done_o, err_o});
        end
        checks++;
        if (wb_adr_o !== 32'd0 || wb_dat_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_bus adr=%h dat=%h exp=0", wb_adr_o, wb_dat_o);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy_o !== 1'b0 || wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset busy=%b cyc=%b exp=0", busy_o, wb_cyc_o);
        end
    endtask

    task automatic test_normal;
        logic [31:0] vals [4];
        int lat, s0, d0, e0;
        vals = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
        for (int i = 0; i < 4; i++) begin
            poke(widx(32'h100, i), vals[i]);
            poke(widx(32'h200, i), 32'd0);
            exp_q.push_back(vals[i]);
        end
        s0 = sel_bad; d0 = done_cnt; e0 = err_hi;
        run_copy(32'h100, 32'h200, 16'd4, lat);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL normal_latency got=%0d exp=17", lat);
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if (mem[widx(32'h200, i)] !== e) begin
                errors++;
                $display("FAIL normal_data[%0d] got=%h exp=%h", i, mem[widx(32'h200, i)], e);
            end
        end
        checks++;
        if (err_hi != e0 || sel_bad != s0) begin
            errors++;
            $display("FAIL normal_err_sel err_cycles=%0d sel_bad=%0d exp=0 0", err_hi - e0, sel_bad - s0);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL normal_done_pulses got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_zero_len;
        int lat, c0, b0, d0;
        c0 = cyc_cnt; b0 = busy_cnt; d0 = done_cnt;
        run_copy(32'h100, 32'h200, 16'd0, lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL zero_latency got=%0d exp=1", lat);
        end
        checks++;
        if (cyc_cnt != c0 || busy_cnt != b0) begin
            errors++;
            $display("FAIL zero_no_bus cyc_cycles=%0d busy_cycles=%0d exp=0 0", cyc_cnt - c0, busy_cnt - b0);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL zero_done_pulses got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_error_abort;
        logic [31:0] v [4];
        int lat, d0;
        for (int i = 0; i < 4; i++) begin
            v[i] = $urandom;
            poke(widx(32'h140, i), v[i]);
            poke(widx(32'h280, i), 32'hDEADBEEF);
        end
        err_adr = 32'h284;
        d0 = done_cnt;
        run_copy(32'h140, 32'h280, 16'd4, lat);
        err_adr = 32'hFFFF_FFFF;
        // one full word (4) + read of word 2 (2) + errored write (2) + done cycle
        checks++;
        if (lat !== 9) begin
            errors++;
            $display("FAIL err_latency got=%0d exp=9", lat);
        end
        checks++;
        if (err_o !== 1'b1 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL err_flag err=%b done_pulses=%0d exp=1 1", err_o, done_cnt - d0);
        end
        checks++;
        if (mem[widx(32'h280, 0)] !== v[0]) begin
            errors++;
            $display("FAIL err_word1 got=%h exp=%h", mem[widx(32'h280, 0)], v[0]);
        end
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (mem[widx(32'h280, i)] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL err_untouched[%0d] got=%h exp=deadbeef", i, mem[widx(32'h280, i)]);
            end
        end
        poke(widx(32'h2C0, 0), 32'd0);
        run_copy(32'h140, 32'h2C0, 16'd1, lat);
        checks++;
        if (err_o !== 1'b0 || lat !== 5 || mem[widx(32'h2C0, 0)] !== v[0]) begin
            errors++;
            $display("FAIL err_recover err=%b lat=%0d data=%h exp=0 5 %h", err_o, lat, mem[widx(32'h2C0, 0)], v[0]);
        end
    endtask

    task automatic test_start_while_busy;
        int lat;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                logic [31:0] r;
                r = $urandom;
                poke(widx(32'h180, i), r);
                exp_q.push_back(r);
            end
            poke(widx(32'h300, i), ~(32'h5A5A0000 + 32'(i)));
            poke(widx(32'h380, i), 32'd0);
        end
        src_adr = 32'h180; dst_adr = 32'h380; len = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        src_adr = 32'h300; dst_adr = 32'h3C0; len = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1;
        for (int k = 3; k <= 2000; k++) begin
            if (done_o) begin
                lat = k;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        checks++;
        if (lat !== 13) begin
            errors++;
            $display("FAIL busy_start_latency got=%0d exp=13", lat);
        end
        for (int i = 0; i < 3; i++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if (mem[widx(32'h380, i)] !== e) begin
                errors++;
                $display("FAIL busy_start_data[%0d] got=%h exp=%h", i, mem[widx(32'h380, i)], e);
            end
        end
        checks++;
        if (mem[widx(32'h380, 3)] !== 32'd0) begin
            errors++;
            $display("FAIL busy_start_len got=%h exp=0", mem[widx(32'h380, 3)]);
        end
    endtask

    task automatic test_reset_mid;
        int lat;
        logic [31:0] v [2];
        bit seen_wr;
        for (int i = 0; i < 2; i++) begin
            v[i] = $urandom;
            poke(widx(32'h1C0, i), v[i]);
            poke(widx(32'h3E0, i), 32'd0);
        end
        src_adr = 32'h1C0; dst_adr = 32'h3E0; len = 16'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seen_wr = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (wb_we_o) begin
                seen_wr = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!seen_wr) begin
            errors++;
            $display("FAIL rst_mid_reach_wr got=0 exp=1");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({wb_cyc_o, wb_stb_o, busy_o, done_o} !== 4'b0) begin
            errors++;
            $display("FAIL rst_mid_async got=%b exp=0000", {wb_cyc_o, wb_stb_o, busy_o, done_o});
        end
        #3 rst = 1'b0;
        @(posedge clk); #1;
        run_copy(32'h1C0, 32'h3E0, 16'd2, lat);
        checks++;
        if (lat !== 9 || mem[widx(32'h3E0, 0)] !== v[0] || mem[widx(32'h3E0, 1)] !== v[1]) begin
            errors++;
            $display("FAIL rst_mid_recover lat=%0d d0=%h d1=%h exp=9 %h %h",
                     lat, mem[widx(32'h3E0, 0)], mem[widx(32'h3E0, 1)], v[0], v[1]);
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 7; it++) begin
            logic [31:0] s, d;
            int n, lat;
            if (it == 6) begin
                s = 32'hFFFF_FFF8 | 32'($urandom_range(0, 3));
                d = 32'h900;
                n = 4;
            end else begin
                s = 32'($urandom_range(0, 200)) << 2;
                d = 32'($urandom_range(512, 760)) << 2;
                n = $urandom_range(1, 8);
            end
            for (int i = 0; i < n; i++) begin
                logic [31:0] r;
                r = $urandom;
                poke(widx(s & 32'hFFFF_FFFC, i), r);
                poke(widx(d, i), ~r);
                exp_q.push_back(r);
            end
            run_copy(s, d, 16'(n), lat);
            checks++;
            if (lat !== 4 * n + 1 || err_o !== 1'b0) begin
                errors++;
                $display("FAIL rand%0d_latency lat=%0d err=%b exp=%0d 0", it, lat, err_o, 4 * n + 1);
            end
            for (int i = 0; i < n; i++) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                checks++;
                if (mem[widx(d, i)] !== e) begin
                    errors++;
                    $display("FAIL rand%0d_data[%0d] got=%h exp=%h", it, i, mem[widx(d, i)], e);
                end
            end
        end
    endtask

`ifdef WB_DMA_TIMEOUT_EN
    task automatic test_timeout;
        int lat;
        mute = 1'b1;
        run_copy(32'h100, 32'h200, 16'd1, lat);
        mute = 1'b0;
        checks++;
        if (lat < 9 || lat > 10) begin
            errors++;
            $display("FAIL timeout_latency got=%0d exp=9..10", lat);
        end
        checks++;
        if (err_o !== 1'b1 || wb_cyc_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_abort err=%b cyc=%b exp=1 0", err_o, wb_cyc_o);
        end
    endtask
`endif

    initial begin
        start = 1'b0; src_adr = '0; dst_adr = '0; len = '0;
        bd_we = 1'b0; bd_idx = '0; bd_dat = '0;
        err_adr = 32'hFFFF_FFFF;
        mute = 1'b0;
        test_reset();
        test_normal();
        test_zero_len();
        test_error_abort();
        test_start_while_busy();
        test_reset_mid();
        test_random();
`ifdef WB_DMA_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
